fifo_rd_rst_gen: RTL

//  Parametrised successor to the read-side FIFO periodic reset logic. Counts
//  rd_en strobes synchronously in the clk domain (rd_en is never used as a clock).

---
 rtl/fifo_rd_rst_gen_if.sv | 45 ++++
 rtl/fifo_rd_rst_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fifo_rd_rst_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_rst_gen_if
// Brief    : Control/status bundle between the frame reader and fifo_rd_rst_gen.
// Revision : 1.0
// ============================================================================
interface fifo_rd_rst_gen_if #(
    parameter int CNT_W = 16,
    parameter int EVT_W = 8
);
    logic             en;
    logic             rd_en;
    logic             force_rst;
    logic             fifo_rd_rst;
    logic             rst_flag;
    logic             rd_block;
    logic             busy;
    logic [CNT_W-1:0] rd_cnt;
    logic [EVT_W-1:0] evt_cnt;

    modport master (
        output en,
        output rd_en,
        output force_rst,
        input  fifo_rd_rst,
        input  rst_flag,
        input  rd_block,
        input  busy,
        input  rd_cnt,
        input  evt_cnt
    );

    modport slave (
        input  en,
        input  rd_en,
        input  force_rst,
        output fifo_rd_rst,
        output rst_flag,
        output rd_block,
        output busy,
        output rd_cnt,
        output evt_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_rst_gen.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_rst_gen
// Brief    : Counts FIFO reads and issues a periodic/forced active-low read
//            reset pulse followed by an optional guard window.
// Revision : 1.0
// ============================================================================
module fifo_rd_rst_gen #(
    parameter int CNT_W         = 16,
    parameter int RD_LIMIT      = 500,
    parameter int RST_PULSE_CYC = 4,
    parameter int GUARD_CYC     = 2,
    parameter int EVT_W         = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fifo_rd_rst_gen_if.slave    bus
);

    localparam logic [1:0] S_COUNT = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;

    localparam int c_TMR_MAX = (RST_PULSE_CYC > GUARD_CYC) ? RST_PULSE_CYC : GUARD_CYC;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam bit c_HAS_GUARD = (GUARD_CYC > 0);

    localparam logic [c_TMR_W-1:0] c_PULSE_LAST = c_TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_GUARD_LAST = c_TMR_W'(c_HAS_GUARD ? GUARD_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]   c_RD_LAST    = CNT_W'(RD_LIMIT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_TMR_W-1:0] w_tmr_nxt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   w_rd_cnt_nxt;
    logic [EVT_W-1:0]   r_evt_cnt;
    logic               w_enter_pulse;

    logic               r_fifo_rd_rst;
    logic               r_rst_flag;
    logic               r_rd_block;
    logic               r_busy;
    logic               w_fifo_rd_rst_nxt;
    logic               w_rd_block_nxt;
    logic               w_busy_nxt;

    // State, timers and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_COUNT;
            r_tmr     <= '0;
            r_rd_cnt  <= '0;
            r_evt_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tmr    <= w_tmr_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
            if (w_enter_pulse) begin
                r_evt_cnt <= r_evt_cnt + 1'b1;
            end
        end
    end

    // Force wins over the threshold so a coincident pair yields one pulse
    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_nxt     = r_tmr;
        w_rd_cnt_nxt  = r_rd_cnt;
        w_enter_pulse = 1'b0;
        case (r_state)
            S_COUNT: begin
                if (bus.force_rst) begin
                    w_rd_cnt_nxt  = '0;
                    w_tmr_nxt     = '0;
                    w_state_nxt   = S_PULSE;
                    w_enter_pulse = 1'b1;
                end else if (bus.en && bus.rd_en) begin
                    if (r_rd_cnt == c_RD_LAST) begin
                        w_rd_cnt_nxt  = '0;
                        w_tmr_nxt     = '0;
                        w_state_nxt   = S_PULSE;
                        w_enter_pulse = 1'b1;
                    end else begin
                        w_rd_cnt_nxt = r_rd_cnt + 1'b1;
                    end
                end
            end
            S_PULSE: begin
                if (r_tmr == c_PULSE_LAST) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = c_HAS_GUARD ? S_GUARD : S_COUNT;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_GUARD: begin
                if (r_tmr == c_GUARD_LAST) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_COUNT;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: begin
                w_tmr_nxt   = '0;
                w_state_nxt = S_COUNT;
            end
        endcase
    end

    // Outputs decoded from the next state so they land on the same edge
    always_comb begin
        w_fifo_rd_rst_nxt = (w_state_nxt != S_PULSE);
        w_rd_block_nxt    = (w_state_nxt == S_PULSE) || (w_state_nxt == S_GUARD);
        w_busy_nxt        = (w_state_nxt != S_COUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_rd_rst <= 1'b1;
            r_rst_flag    <= 1'b1;
            r_rd_block    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_fifo_rd_rst <= w_fifo_rd_rst_nxt;
            r_rst_flag    <= w_fifo_rd_rst_nxt;
            r_rd_block    <= w_rd_block_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign bus.fifo_rd_rst = r_fifo_rd_rst;
    assign bus.rst_flag    = r_rst_flag;
    assign bus.rd_block    = r_rd_block;
    assign bus.busy        = r_busy;
    assign bus.rd_cnt      = r_rd_cnt;
    assign bus.evt_cnt     = r_evt_cnt;

endmodule
`default_nettype wire
